radix8_mul_seq: RTL

- Sequencer placed directly in front of the N-bit CSA radix-8 sequential multiplier (`CSA_radix8_mul`). It also consumes the multiplier's product.
- Accepts operand pairs on a valid/ready interface and holds them stable for the whole multiply.
- Pulses the multiplier's load/reset input, counts the fixed iteration latency, and captures the 2N-bit product on the single cycle it is valid.
- Presents the product on a valid/ready result interface with a one-entry holding register, so the multiplier becomes a streaming, back-pressurable unit.

---
 rtl/radix8_mul_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/radix8_mul_seq.sv
// ---------------------------------------------------------------------------
// radix8_mul_seq
//   Sequencer in front of the CSA radix-8 sequential multiplier. It takes
//   operand pairs on a valid/ready interface and holds them stable for the
//   whole multiply. It pulses the multiplier's load input, then counts the
//   fixed iteration latency. It captures the 2N-bit product on the one edge
//   where that product is valid, and presents it through a one-entry holding
//   register with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   in_valid   operand pair valid
//   in_ready   sequencer can accept an operand pair
//   in_a       signed multiplicand (N)
//   in_x       signed multiplier (N)
//   mul_load   registered load/reset to the multiplier (active high)
//   mul_a      registered multiplicand to the multiplier (N)
//   mul_x      registered multiplier operand to the multiplier (N)
//   mul_p      multiplier product (2N)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_p      signed product (2N)
//   busy       high while a multiply is in flight (LOAD or RUN)
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | multiplier held in load; waiting for an operand pair
// S_LOAD | one cycle with the new mul_x present so the multiplier loads it
// S_RUN  | multiplier iterating; run_cnt counts up to the capture edge
// ---------------------------------------------------------------------------
module radix8_mul_seq #(
    parameter int N       = 32,
    parameter int ITER    = (N + 3) / 3,
    parameter int CAP_DLY = ITER + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_x,
    output logic             mul_load,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_x,
    input  logic [2*N-1:0]   mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic             busy
);

    localparam int            CW       = $clog2(CAP_DLY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CAP_DLY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    run_cnt, run_cnt_nxt;
    logic [N-1:0]     mul_a_nxt, mul_x_nxt;
    logic [2*N-1:0]   out_p_nxt;
    logic             out_valid_nxt;
    logic             mul_load_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            run_cnt   <= '0;
            mul_a     <= '0;
            mul_x     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            mul_load  <= 1'b1;
        end else begin
            state     <= state_nxt;
            run_cnt   <= run_cnt_nxt;
            mul_a     <= mul_a_nxt;
            mul_x     <= mul_x_nxt;
            out_p     <= out_p_nxt;
            out_valid <= out_valid_nxt;
            mul_load  <= mul_load_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        mul_a_nxt   = mul_a;
        mul_x_nxt   = mul_x;
        out_p_nxt   = out_p;
        // A held result drains on any edge where downstream is ready.
        out_valid_nxt = out_valid && !out_ready;
        in_ready      = (state == S_IDLE) && (!out_valid || out_ready);
        busy          = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    mul_a_nxt = in_a;
                    mul_x_nxt = in_x;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                run_cnt_nxt = '0;
                state_nxt   = S_RUN;
            end
            S_RUN: begin
                // The multiplier cannot stall, so mul_p is taken on exactly
                // this edge; the holding register is already empty because
                // acceptance required the previous result to drain.
                if (run_cnt == CNT_LAST) begin
                    out_p_nxt     = mul_p;
                    out_valid_nxt = 1'b1;
                    run_cnt_nxt   = '0;
                    state_nxt     = S_IDLE;
                end else begin
                    run_cnt_nxt = run_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Registered so the multiplier's asynchronous reset never glitches.
        mul_load_nxt = (state_nxt != S_RUN);
    end

endmodule
